// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the parametrised UART transmitter.
// Imported by the transmitter top level.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts CLK_DIV clocks while enabled and emits a one-cycle tick
// on the last clock of each bit. Held at zero whenever disabled.
module uart_baud_tick #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic tick
);

   localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] baud_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt <= '0;
      end else if (!enable || tick) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + CNT_W'(1);
      end
   end

   assign tick = enable && (baud_cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-word holding register so that a queued
// word starts on the very clock its predecessor's last stop bit ends.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLK_DIV   = 16,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int MSB_FIRST = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 uart_txd,
   output logic                 tx_busy,
   output logic                 txd_done
);

   if (CLK_DIV < 2) begin : g_bad_div
      $error("uart_tx_param: CLK_DIV must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("uart_tx_param: DATA_BITS must be in 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end
   if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_order
      $error("uart_tx_param: MSB_FIRST must be 0 or 1");
   end

   localparam int               BIT_W     = $clog2(DATA_BITS + 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
   localparam bit               MSB       = (MSB_FIRST != 0);

   tx_state_e            state, state_next;
   logic [DATA_BITS-1:0] hold_r, shifter, shifter_next;
   logic                 hold_full, hold_full_next;
   logic                 parity_r, parity_next;
   logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
   logic                 stop_cnt, stop_cnt_next;
   logic                 load, done_next, txd_next, accept, tick;

   uart_baud_tick #(
      .CLK_DIV(CLK_DIV)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .enable(state != ST_IDLE),
      .tick  (tick)
   );

   assign accept         = tx_valid && tx_ready;
   assign hold_full_next = (hold_full && !load) || accept;
   assign tx_busy        = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A load happens from IDLE or at the end of a frame; either way the queued word
   // moves into the shifter and its parity is captured before the hold can refill.
   always_comb begin
      state_next    = state;
      shifter_next  = shifter;
      parity_next   = parity_r;
      bit_cnt_next  = bit_cnt;
      stop_cnt_next = stop_cnt;
      load          = 1'b0;
      done_next     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (hold_full) load = 1'b1;
         end
         ST_START: begin
            if (tick) begin
               state_next   = ST_DATA;
               bit_cnt_next = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_cnt == LAST_BIT) begin
                  state_next    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                  stop_cnt_next = 1'b0;
               end else begin
                  bit_cnt_next = bit_cnt + BIT_W'(1);
                  shifter_next = MSB ? {shifter[DATA_BITS-2:0], 1'b0}
                                     : {1'b0, shifter[DATA_BITS-1:1]};
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_next    = ST_STOP;
               stop_cnt_next = 1'b0;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (stop_cnt == STOP_LAST) begin
                  done_next = 1'b1;
                  if (hold_full) load = 1'b1;
                  else           state_next = ST_IDLE;
               end else begin
                  stop_cnt_next = 1'b1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (load) begin
         state_next   = ST_START;
         shifter_next = hold_r;
         parity_next  = (PARITY == PARITY_ODD) ? ~^hold_r : ^hold_r;
      end
   end

   // The line is registered from the next state so each bit appears on the edge
   // that enters it, keeping uart_txd glitch-free at the pad.
   always_comb begin
      txd_next = 1'b1;
      unique case (state_next)
         ST_START:  txd_next = 1'b0;
         ST_DATA:   txd_next = MSB ? shifter_next[DATA_BITS-1] : shifter_next[0];
         ST_PARITY: txd_next = parity_next;
         default:   txd_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_r    <= '0;
         hold_full <= 1'b0;
         tx_ready  <= 1'b1;
         shifter   <= '0;
         parity_r  <= 1'b0;
         bit_cnt   <= '0;
         stop_cnt  <= 1'b0;
         uart_txd  <= 1'b1;
         txd_done  <= 1'b0;
      end else begin
         if (accept) hold_r <= data_in;
         hold_full <= hold_full_next;
         tx_ready  <= !hold_full_next;
         shifter   <= shifter_next;
         parity_r  <= parity_next;
         bit_cnt   <= bit_cnt_next;
         stop_cnt  <= stop_cnt_next;
         uart_txd  <= txd_next;
         txd_done  <= done_next;
      end
   end

endmodule
